neuron_acc: RTL and testbench

- Downstream consumer of the 8x8 MAC stage. Accumulates one neuron's signed 17-bit products plus a bias over NUM_INPUTS products.
- Applies ReLU, then rounding right-shift requantisation with unsigned 8-bit saturation.
- Presents the quantised activation and the raw signed sum with a one-cycle valid pulse.
- Feeds the next layer's input_feature path and the argmax/classifier (raw_sum).

---
 rtl/neuron_acc.sv | 97 +++++++++
 tb/tb_neuron_acc.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_acc.sv
// Neuron accumulator: sums a signed bias plus NUM_INPUTS signed MAC products,
// then applies ReLU and rounding right-shift requantisation to an unsigned byte.
module neuron_acc #(
    parameter int NUM_INPUTS = 784,
    parameter int ACC_WIDTH  = 27,
    parameter int SHIFT      = 7
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        start,
    input  logic signed [15:0]          bias,
    input  logic signed [16:0]          mac_result,
    input  logic                        mac_done,
    output logic [7:0]                  output_feature,
    output logic signed [ACC_WIDTH-1:0] raw_sum,
    output logic                        valid,
    output logic                        busy
);

    localparam int CW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_INPUTS - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, FINISH} state_t;

    state_t                      state, state_next;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] bias_ext;
    logic signed [ACC_WIDTH-1:0] mac_ext;
    logic [CW-1:0]               count;
    logic signed [ACC_WIDTH:0]   rounded;
    logic signed [ACC_WIDTH:0]   scaled;
    logic [7:0]                  quant;

    assign bias_ext = {{(ACC_WIDTH-16){bias[15]}}, bias};
    assign mac_ext  = {{(ACC_WIDTH-17){mac_result[16]}}, mac_result};
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ACCUM;
            ACCUM:   if (!start && mac_done && count == LAST) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One extra bit keeps the rounding offset from overflowing a near-full accumulator.
    always_comb begin
        rounded = {acc[ACC_WIDTH-1], acc} + ((ACC_WIDTH+1)'(1) << (SHIFT - 1));
        scaled  = rounded >>> SHIFT;
        quant   = 8'd0;
        if (!acc[ACC_WIDTH-1] && acc != '0)
            quant = (|scaled[ACC_WIDTH:8]) ? 8'hFF : scaled[7:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc            <= '0;
            count          <= '0;
            output_feature <= '0;
            raw_sum        <= '0;
            valid          <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= bias_ext;
                        count <= '0;
                    end
                end
                ACCUM: begin
                    if (start) begin
                        acc   <= bias_ext;
                        count <= '0;
                    end else if (mac_done) begin
                        acc   <= acc + mac_ext;
                        count <= count + 1'b1;
                    end
                end
                FINISH: begin
                    raw_sum        <= acc;
                    output_feature <= quant;
                    valid          <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_acc.sv
// Bench for neuron_acc: a small instance (4 inputs, shift 2) and a full-size one
// (784 inputs, shift 7), each with a scoreboard queue checked on every valid pulse.
module tb_neuron_acc;

    typedef struct {
        int raw;
        int feat;
        int due;
    } exp_t;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               start_a = 1'b0;
    logic               start_b = 1'b0;
    logic signed [15:0] bias = '0;
    logic signed [16:0] mac_result = '0;
    logic               mac_done = 1'b0;

    logic [7:0]         feat_a, feat_b;
    logic signed [26:0] raw_a, raw_b;
    logic               valid_a, valid_b, busy_a, busy_b;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    neuron_acc #(.NUM_INPUTS(4), .ACC_WIDTH(27), .SHIFT(2)) dut_a (
        .clk(clk), .rstn(rstn), .start(start_a), .bias(bias),
        .mac_result(mac_result), .mac_done(mac_done),
        .output_feature(feat_a), .raw_sum(raw_a), .valid(valid_a), .busy(busy_a)
    );

    neuron_acc #(.NUM_INPUTS(784), .ACC_WIDTH(27), .SHIFT(7)) dut_b (
        .clk(clk), .rstn(rstn), .start(start_b), .bias(bias),
        .mac_result(mac_result), .mac_done(mac_done),
        .output_feature(feat_b), .raw_sum(raw_b), .valid(valid_b), .busy(busy_b)
    );

    function automatic int exp_feat(int s, int sh);
        int r;
        if (s <= 0) return 0;
        r = (s + (1 << (sh - 1))) / (1 << sh);
        return (r > 255) ? 255 : r;
    endfunction

    // Scoreboard for the small instance: every valid must match the oldest expectation.
    always @(negedge clk) begin
        if (valid_a) begin
            exp_t e;
            total++;
            if (q_a.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_valid_a: got valid=1 with no result pending, required none");
            end else begin
                e = q_a.pop_front();
                if (raw_a !== e.raw[26:0]) begin
                    bad++;
                    $display("[TB] FAIL raw_sum_a: got %0d required %0d", raw_a, e.raw);
                end
                total++;
                if (feat_a !== e.feat[7:0]) begin
                    bad++;
                    $display("[TB] FAIL feature_a: got %0d required %0d", feat_a, e.feat);
                end
                total++;
                if (cyc !== e.due) begin
                    bad++;
                    $display("[TB] FAIL latency_a: valid at cycle %0d required %0d", cyc, e.due);
                end
                total++;
                if (busy_a !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL busy_at_valid_a: got %b required 0", busy_a);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (valid_b) begin
            exp_t e;
            total++;
            if (q_b.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_valid_b: got valid=1 with no result pending, required none");
            end else begin
                e = q_b.pop_front();
                if (raw_b !== e.raw[26:0]) begin
                    bad++;
                    $display("[TB] FAIL raw_sum_b: got %0d required %0d", raw_b, e.raw);
                end
                total++;
                if (feat_b !== e.feat[7:0]) begin
                    bad++;
                    $display("[TB] FAIL feature_b: got %0d required %0d", feat_b, e.feat);
                end
                total++;
                if (cyc !== e.due) begin
                    bad++;
                    $display("[TB] FAIL latency_b: valid at cycle %0d required %0d", cyc, e.due);
                end
            end
        end
    end

    task automatic drive(input logic sa, input logic sb, input int b, input logic md, input int mr);
        @(negedge clk);
        start_a    = sa;
        start_b    = sb;
        bias       = 16'(b);
        mac_done   = md;
        mac_result = 17'(mr);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 0, 1'b0, 0);
    endtask

    // Drives one neuron into the small instance and queues its expected result.
    task automatic neuron_a(input int b, input int vals[4], input int gaps[4]);
        int sum;
        exp_t e;
        sum = b;
        drive(1'b1, 1'b0, b, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            idle(gaps[i]);
            drive(1'b0, 1'b0, 0, 1'b1, vals[i]);
            sum += vals[i];
        end
        e.raw  = sum;
        e.feat = exp_feat(sum, 2);
        e.due  = cyc + 2;
        q_a.push_back(e);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #1;
        total++;
        if ({feat_a, raw_a, valid_a, busy_a} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_a: got feat=%0d raw=%0d valid=%b busy=%b required all 0",
                     feat_a, raw_a, valid_a, busy_a);
        end
        total++;
        if ({feat_b, raw_b, valid_b, busy_b} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_b: got feat=%0d raw=%0d valid=%b busy=%b required all 0",
                     feat_b, raw_b, valid_b, busy_b);
        end
        idle(2);
        rstn = 1'b1;
        idle(2);
    endtask

    task automatic test_basic();
        neuron_a(10, '{100, 200, -50, 30}, '{0, 0, 0, 0});
        total++;
        if (busy_a !== 1'b1) begin
            bad++;
            $display("[TB] FAIL busy_accum: got %b required 1", busy_a);
        end
        idle(5);
    endtask

    task automatic test_relu();
        neuron_a(0, '{-5, -5, -5, -5}, '{0, 0, 0, 0});
        idle(5);
    endtask

    task automatic test_saturation_rounding();
        neuron_a(0, '{16320, 16320, 16320, 16320}, '{0, 0, 0, 0});
        idle(4);
        neuron_a(1, '{0, 0, 0, 0}, '{0, 0, 0, 0});
        idle(4);
        neuron_a(2, '{0, 0, 0, 0}, '{0, 0, 0, 0});
        idle(5);
    endtask

    task automatic test_gaps_ignored();
        exp_t e;
        drive(1'b0, 1'b0, 0, 1'b1, 77);
        drive(1'b0, 1'b0, 0, 1'b1, -300);
        idle(1);
        drive(1'b1, 1'b0, 0, 1'b1, 999);
        drive(1'b0, 1'b0, 0, 1'b1, 1);
        idle(1);
        drive(1'b0, 1'b0, 0, 1'b1, 2);
        idle(3);
        drive(1'b0, 1'b0, 0, 1'b1, 3);
        idle(2);
        drive(1'b0, 1'b0, 0, 1'b1, 4);
        e.raw  = 10;
        e.feat = exp_feat(10, 2);
        e.due  = cyc + 2;
        q_a.push_back(e);
        idle(5);
    endtask

    task automatic test_abort();
        drive(1'b1, 1'b0, 33, 1'b0, 0);
        drive(1'b0, 1'b0, 0, 1'b1, 1000);
        drive(1'b0, 1'b0, 0, 1'b1, 2000);
        idle(1);
        drive(1'b1, 1'b0, -7, 1'b1, 500);
        drive(1'b0, 1'b0, 0, 1'b1, 8);
        drive(1'b0, 1'b0, 0, 1'b1, 8);
        drive(1'b0, 1'b0, 0, 1'b1, 8);
        drive(1'b0, 1'b0, 0, 1'b1, 8);
        begin
            exp_t e;
            e.raw  = 25;
            e.feat = exp_feat(25, 2);
            e.due  = cyc + 2;
            q_a.push_back(e);
        end
        idle(5);
    endtask

    task automatic test_back_to_back();
        neuron_a(-100, '{50, 60, 70, 80}, '{0, 0, 0, 0});
        idle(1);
        neuron_a(3, '{-1, 400, 0, 12}, '{0, 0, 1, 0});
        idle(6);
        total++;
        if (q_a.size() != 0) begin
            bad++;
            $display("[TB] FAIL pending_a: %0d results never produced, required 0", q_a.size());
        end
    endtask

    task automatic test_reset_full_size();
        int sum;
        exp_t e;
        drive(1'b0, 1'b1, -32768, 1'b0, 0);
        for (int i = 0; i < 400; i++) drive(1'b0, 1'b0, 0, 1'b1, -32640);
        @(negedge clk);
        rstn     = 1'b0;
        mac_done = 1'b0;
        #1;
        total++;
        if ({feat_b, raw_b, valid_b, busy_b} !== '0) begin
            bad++;
            $display("[TB] FAIL midrun_reset_b: got feat=%0d raw=%0d valid=%b busy=%b required all 0",
                     feat_b, raw_b, valid_b, busy_b);
        end
        total++;
        if ({feat_a, raw_a} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_clears_a: got feat=%0d raw=%0d required 0", feat_a, raw_a);
        end
        idle(3);
        rstn = 1'b1;
        idle(3);

        sum = -32768;
        drive(1'b0, 1'b1, -32768, 1'b0, 0);
        for (int i = 0; i < 784; i++) begin
            drive(1'b0, 1'b0, 0, 1'b1, -32640);
            sum += -32640;
        end
        e.raw  = sum;
        e.feat = exp_feat(sum, 7);
        e.due  = cyc + 2;
        q_b.push_back(e);
        idle(6);
        total++;
        if (q_b.size() != 0) begin
            bad++;
            $display("[TB] FAIL pending_b: %0d results never produced, required 0", q_b.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_relu();
        test_saturation_rounding();
        test_gaps_ignored();
        test_abort();
        test_back_to_back();
        test_reset_full_size();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
